// File: rtl/dds_phase_gen.sv
// dds_phase_gen
//   Phase accumulator and half-wave LUT address generator for the DDS
//   datapath. A tuning word is accepted over a valid/ready handshake. While
//   the accumulator is running, a new word is parked until the next
//   accumulator wrap, so frequency changes keep the phase continuous.
//
// Parameters
//   ACC_W    accumulator width in bits (>= 10)
//   LUT_LAT  LUT read latency in clocks (0..4)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         accumulate enable; the accumulator holds while low
//   phase_clr  synchronous accumulator clear; overrides en
//   tw_data    tuning word
//   tw_valid   tuning word offered
//   tw_ready   a tuning word can be accepted (FSM idle)
//   lut_addr   half-wave LUT address, phase[8:0], taken from the acc register
//   f1         10-bit phase code aligned with the LUT read data
//   wrap       first sample after an accumulator overflow, aligned with f1
//   out_valid  the f1/LUT data pair is valid
module dds_phase_gen #(
    parameter int ACC_W   = 24,
    parameter int LUT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             phase_clr,
    input  logic [ACC_W-1:0] tw_data,
    input  logic             tw_valid,
    output logic             tw_ready,
    output logic [8:0]       lut_addr,
    output logic [9:0]       f1,
    output logic             wrap,
    output logic             out_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] tw_active_q;
    logic [ACC_W-1:0] tw_pend_q;
    logic             ovf_q;
    logic             acc_v_q;

    logic [ACC_W:0]   sum;
    logic             acc_en;
    logic             ovf;
    logic             xfer;
    logic [9:0]       phase;
    logic [11:0]      stage0;

    assign acc_en   = en && !phase_clr;
    assign sum      = {1'b0, acc_q} + {1'b0, tw_active_q};
    // Only adds that actually land in acc count as overflows.
    assign ovf      = acc_en && sum[ACC_W];
    assign tw_ready = (state_q == IDLE);
    assign xfer     = tw_valid && tw_ready;
    assign phase    = acc_q[ACC_W-1 -: 10];
    assign lut_addr = phase[8:0];

    always_comb begin
        acc_d = acc_q;
        if (phase_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            acc_v_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ovf_q   <= ovf;
            acc_v_q <= acc_en;
        end
    end

    // Tuning-word FSM. A word accepted while running waits in tw_pend until
    // an overflow (the overflowing add still uses the old word), or until the
    // accumulator stops or is cleared, when there is no phase to preserve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tw_active_q <= '0;
            tw_pend_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        if (!en) begin
                            tw_active_q <= tw_data;
                        end else begin
                            tw_pend_q <= tw_data;
                            state_q   <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (ovf || !en || phase_clr) begin
                        tw_active_q <= tw_pend_q;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    // Stage-0 sample: {valid, overflow, phase}, delayed to match the LUT.
    assign stage0 = {acc_v_q, ovf_q, phase};

    generate
        if (LUT_LAT == 0) begin : g_lat0
            assign {out_valid, wrap, f1} = stage0;
        end else begin : g_latn
            logic [11:0] pipe_q [LUT_LAT];

            for (genvar g = 0; g < LUT_LAT; g++) begin : g_stage
                if (g == 0) begin : g_first
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            pipe_q[g] <= '0;
                        end else begin
                            pipe_q[g] <= stage0;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            pipe_q[g] <= '0;
                        end else begin
                            pipe_q[g] <= pipe_q[g-1];
                        end
                    end
                end
            end

            assign {out_valid, wrap, f1} = pipe_q[LUT_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_dds_phase_gen.sv
// tb_dds_phase_gen
//   Directed self-checking bench for dds_phase_gen with ACC_W=24, LUT_LAT=1.
//   Inputs are driven and outputs sampled on the falling clock edge; every
//   expected value is a hand-derived constant or closed-form phase sequence.
module tb_dds_phase_gen;

    localparam int ACC_W   = 24;
    localparam int LUT_LAT = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             phase_clr;
    logic [ACC_W-1:0] tw_data;
    logic             tw_valid;
    logic             tw_ready;
    logic [8:0]       lut_addr;
    logic [9:0]       f1;
    logic             wrap;
    logic             out_valid;

    int checks   = 0;
    int failures = 0;

    // 10 MHz
    always #50 clk = ~clk;

    dds_phase_gen #(
        .ACC_W   (ACC_W),
        .LUT_LAT (LUT_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .phase_clr (phase_clr),
        .tw_data   (tw_data),
        .tw_valid  (tw_valid),
        .tw_ready  (tw_ready),
        .lut_addr  (lut_addr),
        .f1        (f1),
        .wrap      (wrap),
        .out_valid (out_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        phase_clr = 1'b0;
        tw_valid  = 1'b0;
        tw_data   = '0;

        // Power-on reset
        repeat (2) @(negedge clk);
        chk("rst_lut",   32'(lut_addr),  0);
        chk("rst_f1",    32'(f1),        0);
        chk("rst_wrap",  32'(wrap),      0);
        chk("rst_ov",    32'(out_valid), 0);
        chk("rst_ready", 32'(tw_ready),  1);
        rst_n = 1'b1;

        @(negedge clk);
        chk("rel_lut",   32'(lut_addr),  0);
        chk("rel_ov",    32'(out_valid), 0);
        chk("rel_ready", 32'(tw_ready),  1);

        // Load 0x010000 with en=0: goes straight to the active word
        tw_valid = 1'b1;
        tw_data  = 24'h010000;
        @(negedge clk);
        chk("load_ready", 32'(tw_ready), 1);
        chk("load_lut",   32'(lut_addr), 0);
        tw_valid = 1'b0;
        en       = 1'b1;

        // Basic rate: phase +4 per clock, overflow on edge 256
        for (int n = 1; n <= 260; n++) begin
            @(negedge clk);
            chk("rate_lut",  32'(lut_addr), (4 * n) % 512);
            chk("rate_wrap", 32'(wrap),     (n == 257) ? 1 : 0);
            if (n >= 2) begin
                chk("rate_f1", 32'(f1),        (4 * (n - 1)) % 1024);
                chk("rate_ov", 32'(out_valid), 1);
            end else begin
                chk("rate_ov0", 32'(out_valid), 0);
            end
        end

        // Phase-continuous change to 0x020000, pending until overflow at edge 512
        tw_valid = 1'b1;
        tw_data  = 24'h020000;
        for (int n = 261; n <= 514; n++) begin
            @(negedge clk);
            tw_valid = 1'b0;
            chk("chg_ready", 32'(tw_ready), (n < 512) ? 0 : 1);
            chk("chg_lut",   32'(lut_addr), (n <= 512) ? (4 * n) % 512 : (8 * (n - 512)) % 512);
            chk("chg_wrap",  32'(wrap),     (n == 513) ? 1 : 0);
            chk("chg_f1",    32'(f1),       (n <= 513) ? (4 * (n - 1)) % 1024 : 8 * (n - 513));
        end

        // en low for 5 clocks (edges 515..519), phase held at 16
        en = 1'b0;
        for (int k = 515; k <= 521; k++) begin
            @(negedge clk);
            chk("gate_lut",  32'(lut_addr),  (k <= 519) ? 16 : ((k == 520) ? 24 : 32));
            chk("gate_ov",   32'(out_valid), (k >= 516 && k <= 520) ? 0 : 1);
            chk("gate_f1",   32'(f1),        (k <= 520) ? 16 : 24);
            chk("gate_wrap", 32'(wrap),      0);
            if (k == 519) en = 1'b1;
        end

        // Clear and load 0x004000 (+1 phase per clock) with en=0
        en        = 1'b0;
        phase_clr = 1'b1;
        tw_valid  = 1'b1;
        tw_data   = 24'h004000;
        @(negedge clk);
        chk("fclr_lut",   32'(lut_addr), 0);
        chk("fclr_ready", 32'(tw_ready), 1);
        chk("fclr_wrap",  32'(wrap),     0);
        phase_clr = 1'b0;
        tw_valid  = 1'b0;
        en        = 1'b1;

        // Fold boundary and full-cycle wrap: phase m after the m-th edge
        for (int m = 1; m <= 1026; m++) begin
            @(negedge clk);
            chk("fold_lut",  32'(lut_addr), m % 512);
            chk("fold_wrap", 32'(wrap),     (m == 1025) ? 1 : 0);
            if (m >= 2) begin
                chk("fold_f1", 32'(f1), (m - 1) % 1024);
            end
        end

        // phase_clr while a word is pending (phase currently 2)
        tw_valid = 1'b1;
        tw_data  = 24'h010000;
        @(negedge clk);
        chk("pclr_pend_ready", 32'(tw_ready), 0);
        chk("pclr_pend_lut",   32'(lut_addr), 3);
        tw_valid  = 1'b0;
        phase_clr = 1'b1;
        @(negedge clk);
        chk("pclr_lut",   32'(lut_addr), 0);
        chk("pclr_ready", 32'(tw_ready), 1);
        chk("pclr_wrap",  32'(wrap),     0);
        chk("pclr_f1",    32'(f1),       3);
        phase_clr = 1'b0;
        @(negedge clk);
        chk("pclr_new_lut", 32'(lut_addr),  4);
        chk("pclr_wrap2",   32'(wrap),      0);
        chk("pclr_f1_0",    32'(f1),        0);
        chk("pclr_ov0",     32'(out_valid), 0);
        @(negedge clk);
        chk("pclr_lut8", 32'(lut_addr),  8);
        chk("pclr_f1_4", 32'(f1),        4);
        chk("pclr_ov1",  32'(out_valid), 1);

        // Asynchronous reset while a word is pending
        tw_valid = 1'b1;
        tw_data  = 24'h020000;
        @(negedge clk);
        chk("mrst_pend_ready", 32'(tw_ready), 0);
        chk("mrst_pend_lut",   32'(lut_addr), 12);
        tw_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mrst_lut",   32'(lut_addr),  0);
        chk("mrst_f1",    32'(f1),        0);
        chk("mrst_wrap",  32'(wrap),      0);
        chk("mrst_ov",    32'(out_valid), 0);
        chk("mrst_ready", 32'(tw_ready),  1);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrel_lut",   32'(lut_addr),  0);
        chk("mrel_ov",    32'(out_valid), 0);
        chk("mrel_ready", 32'(tw_ready),  1);
        en = 1'b1;
        // Pending word was discarded and the active word is 0: acc holds
        @(negedge clk);
        chk("mrun_lut",   32'(lut_addr), 0);
        chk("mrun_ready", 32'(tw_ready), 1);
        @(negedge clk);
        chk("mrun_lut2", 32'(lut_addr),  0);
        chk("mrun_ov",   32'(out_valid), 1);
        chk("mrun_wrap", 32'(wrap),      0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
